// File: rtl/execute_mul_pkg.sv
// Shared widths, encodings and payload type for the mul issue path.
package execute_mul_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROB_W     = 4;
    localparam int unsigned FID_W     = 8;
    localparam int unsigned MUL_CMD_W = 1;

    // Mul command: which half of the 64-bit product the op wants.
    typedef enum logic [MUL_CMD_W-1:0] {
        MUL_CMD_LOW  = 1'b0,
        MUL_CMD_HIGH = 1'b1
    } mul_cmd_e;

    // Round-robin priority pointer: requester that wins a tie.
    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } rr_prio_e;

    // One issued mul op as seen by the mul input stage.
    typedef struct packed {
        logic [DATA_W-1:0]    src0;
        logic [DATA_W-1:0]    src1;
        logic [ROB_W-1:0]     dst_rob;
        logic [FID_W-1:0]     fid;
        logic [MUL_CMD_W-1:0] mul_cmd;
    } mul_op_t;

endpackage

// File: rtl/execute_mul_sched_if.sv
// Bus bundle of the mul scheduler: two requesters, flush, credit return,
// issued op and credit status.
//   master : requester/downstream side (drives i_*, observes o_*)
//   slave  : scheduler side (observes i_*, drives o_*)
interface execute_mul_sched_if #(
    parameter int unsigned CREDITS = 4
);
    import execute_mul_pkg::*;

    localparam int unsigned CRED_W = $clog2(CREDITS + 1);

    logic                 i_req0_valid;
    logic [DATA_W-1:0]    i_req0_src0_value;
    logic [DATA_W-1:0]    i_req0_src1_value;
    logic [ROB_W-1:0]     i_req0_dst_rob;
    logic [FID_W-1:0]     i_req0_fid;
    logic [MUL_CMD_W-1:0] i_req0_mul_cmd;
    logic                 o_req0_ready;

    logic                 i_req1_valid;
    logic [DATA_W-1:0]    i_req1_src0_value;
    logic [DATA_W-1:0]    i_req1_src1_value;
    logic [ROB_W-1:0]     i_req1_dst_rob;
    logic [FID_W-1:0]     i_req1_fid;
    logic [MUL_CMD_W-1:0] i_req1_mul_cmd;
    logic                 o_req1_ready;

    logic                 i_flush;
    logic                 i_result_pop;

    logic                 o_valid;
    logic [DATA_W-1:0]    o_src0_value;
    logic [DATA_W-1:0]    o_src1_value;
    logic [ROB_W-1:0]     o_dst_rob;
    logic [FID_W-1:0]     o_fid;
    logic [MUL_CMD_W-1:0] o_mul_cmd;
    logic [CRED_W-1:0]    o_credits;
    logic                 o_credit_err;

    modport master (
        output i_req0_valid, i_req0_src0_value, i_req0_src1_value,
               i_req0_dst_rob, i_req0_fid, i_req0_mul_cmd,
        output i_req1_valid, i_req1_src0_value, i_req1_src1_value,
               i_req1_dst_rob, i_req1_fid, i_req1_mul_cmd,
        output i_flush, i_result_pop,
        input  o_req0_ready, o_req1_ready,
        input  o_valid, o_src0_value, o_src1_value, o_dst_rob, o_fid,
               o_mul_cmd, o_credits, o_credit_err
    );

    modport slave (
        input  i_req0_valid, i_req0_src0_value, i_req0_src1_value,
               i_req0_dst_rob, i_req0_fid, i_req0_mul_cmd,
        input  i_req1_valid, i_req1_src0_value, i_req1_src1_value,
               i_req1_dst_rob, i_req1_fid, i_req1_mul_cmd,
        input  i_flush, i_result_pop,
        output o_req0_ready, o_req1_ready,
        output o_valid, o_src0_value, o_src1_value, o_dst_rob, o_fid,
               o_mul_cmd, o_credits, o_credit_err
    );

endinterface

// File: rtl/execute_mul_rr_arb.sv
// Two-way round-robin arbiter with enable.
//   clk, resetn : clock, async active-low reset
//   i_en        : grants allowed this cycle
//   i_valid     : per-requester request
//   o_grant_c   : one-hot grant (combinational); pointer flips to the loser
module execute_mul_rr_arb
    import execute_mul_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant_c
);

    rr_prio_e   r_prio;
    rr_prio_e   w_prio_nxt;
    logic [1:0] w_grant;

    // Priority pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prio <= PRIO_REQ0;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    // Grant select and pointer update; no grant leaves the pointer alone.
    always_comb begin
        w_grant    = 2'b00;
        w_prio_nxt = r_prio;
        if (i_en) begin
            if (i_valid == 2'b11) begin
                w_grant = (r_prio == PRIO_REQ0) ? 2'b01 : 2'b10;
            end else begin
                w_grant = i_valid;
            end
        end
        if (w_grant[0]) begin
            w_prio_nxt = PRIO_REQ1;
        end else if (w_grant[1]) begin
            w_prio_nxt = PRIO_REQ0;
        end
    end

    assign o_grant_c = w_grant;

endmodule

// File: rtl/execute_mul_sched.sv
// Mul issue scheduler: picks one of two requesters per cycle, gated by
// downstream result-buffer credits and flush, and registers the issued op.
//   clk, resetn : clock, async active-low reset
//   bus         : requester inputs/readies, flush, credit pop, issued op,
//                 free-credit count and sticky credit-overflow flag
module execute_mul_sched
    import execute_mul_pkg::*;
#(
    parameter int unsigned CREDITS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    execute_mul_sched_if.slave  bus
);

    localparam int unsigned CRED_W = $clog2(CREDITS + 1);

    logic [CRED_W-1:0] r_credits;
    logic [CRED_W-1:0] w_credits_nxt;
    logic              r_credit_err;
    logic              w_credit_err_nxt;
    logic              r_valid;
    mul_op_t           r_op;

    logic [1:0]        w_grant;
    logic              w_en;
    logic              w_issue;
    mul_op_t           w_req0_op;
    mul_op_t           w_req1_op;
    mul_op_t           w_sel_op;

    assign w_req0_op = '{src0:    bus.i_req0_src0_value,
                         src1:    bus.i_req0_src1_value,
                         dst_rob: bus.i_req0_dst_rob,
                         fid:     bus.i_req0_fid,
                         mul_cmd: bus.i_req0_mul_cmd};
    assign w_req1_op = '{src0:    bus.i_req1_src0_value,
                         src1:    bus.i_req1_src1_value,
                         dst_rob: bus.i_req1_dst_rob,
                         fid:     bus.i_req1_fid,
                         mul_cmd: bus.i_req1_mul_cmd};

    // A pop in the same cycle never unlocks issue at zero credits.
    assign w_en = (r_credits != '0) && !bus.i_flush;

    execute_mul_rr_arb u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .i_en      (w_en),
        .i_valid   ({bus.i_req1_valid, bus.i_req0_valid}),
        .o_grant_c (w_grant)
    );

    assign w_issue  = |w_grant;
    assign w_sel_op = w_grant[1] ? w_req1_op : w_req0_op;

    // Credit bookkeeping; a pop with every credit already home is an overflow.
    always_comb begin
        w_credits_nxt    = r_credits;
        w_credit_err_nxt = r_credit_err;
        case ({w_issue, bus.i_result_pop})
            2'b10: w_credits_nxt = r_credits - CRED_W'(1);
            2'b01: begin
                if (r_credits == CRED_W'(CREDITS)) begin
                    w_credit_err_nxt = 1'b1;
                end else begin
                    w_credits_nxt = r_credits + CRED_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_credits    <= CRED_W'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            r_credits    <= w_credits_nxt;
            r_credit_err <= w_credit_err_nxt;
        end
    end

    // Issue register: payload holds its last value when nothing is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_op    <= '0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_op <= w_sel_op;
            end
        end
    end

    assign bus.o_req0_ready = w_grant[0];
    assign bus.o_req1_ready = w_grant[1];
    assign bus.o_valid      = r_valid;
    assign bus.o_src0_value = r_op.src0;
    assign bus.o_src1_value = r_op.src1;
    assign bus.o_dst_rob    = r_op.dst_rob;
    assign bus.o_fid        = r_op.fid;
    assign bus.o_mul_cmd    = r_op.mul_cmd;
    assign bus.o_credits    = r_credits;
    assign bus.o_credit_err = r_credit_err;

endmodule

// File: tb/tb_execute_mul_sched.sv
// Bench for execute_mul_sched: directed table, mid-stream reset, random run.
module tb_execute_mul_sched;
    import execute_mul_pkg::*;

    localparam int unsigned CREDITS = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    execute_mul_sched_if #(.CREDITS(CREDITS)) bus ();

    execute_mul_sched #(.CREDITS(CREDITS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: free credits, tie-break owner, sticky error, issue reg.
    int      m_credits;
    int      m_ptr;
    bit      m_err;
    bit      m_valid;
    mul_op_t m_op;

    typedef struct {
        bit v0, v1, fl, pp;
        bit er0, er1;
        int ecred;
        bit eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic mul_op_t rand_op();
        mul_op_t op;
        op.src0    = $urandom;
        op.src1    = $urandom;
        op.dst_rob = ROB_W'($urandom);
        op.fid     = FID_W'($urandom);
        op.mul_cmd = MUL_CMD_W'($urandom);
        return op;
    endfunction

    function automatic vec_t mk(bit v0, bit v1, bit fl, bit pp, bit er0, bit er1, int ecred, bit eerr);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.fl = fl; v.pp = pp;
        v.er0 = er0; v.er1 = er1; v.ecred = ecred; v.eerr = eerr;
        return v;
    endfunction

    task automatic model_reset();
        m_credits = CREDITS;
        m_ptr     = 0;
        m_err     = 1'b0;
        m_valid   = 1'b0;
        m_op      = '0;
    endtask

    // Which requester the rules pick this cycle, -1 for none.
    function automatic int model_grant(bit v0, bit v1, bit fl);
        if (fl || m_credits == 0) return -1;
        if (v0 && v1) return m_ptr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic drive(input bit v0, input bit v1, input bit fl, input bit pp,
                         input mul_op_t p0, input mul_op_t p1);
        bus.i_req0_valid      = v0;
        bus.i_req0_src0_value = p0.src0;
        bus.i_req0_src1_value = p0.src1;
        bus.i_req0_dst_rob    = p0.dst_rob;
        bus.i_req0_fid        = p0.fid;
        bus.i_req0_mul_cmd    = p0.mul_cmd;
        bus.i_req1_valid      = v1;
        bus.i_req1_src0_value = p1.src0;
        bus.i_req1_src1_value = p1.src1;
        bus.i_req1_dst_rob    = p1.dst_rob;
        bus.i_req1_fid        = p1.fid;
        bus.i_req1_mul_cmd    = p1.mul_cmd;
        bus.i_flush           = fl;
        bus.i_result_pop      = pp;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, " o_valid"},  32'(bus.o_valid),      32'(m_valid));
        chk({tag, " src0"},     bus.o_src0_value,      m_op.src0);
        chk({tag, " src1"},     bus.o_src1_value,      m_op.src1);
        chk({tag, " dst_rob"},  32'(bus.o_dst_rob),    32'(m_op.dst_rob));
        chk({tag, " fid"},      32'(bus.o_fid),        32'(m_op.fid));
        chk({tag, " mul_cmd"},  32'(bus.o_mul_cmd),    32'(m_op.mul_cmd));
        chk({tag, " credits"},  32'(bus.o_credits),    32'(m_credits));
        chk({tag, " cred_err"}, 32'(bus.o_credit_err), 32'(m_err));
    endtask

    // One clock: drive after posedge, check at negedge, advance model at posedge.
    task automatic run_cycle(input bit v0, input bit v1, input bit fl, input bit pp,
                             input mul_op_t p0, input mul_op_t p1,
                             output bit r0, output bit r1, output int cred, output bit err,
                             output bit ov, output mul_op_t oop);
        int g;
        drive(v0, v1, fl, pp, p0, p1);
        @(negedge clk);
        g    = model_grant(v0, v1, fl);
        r0   = bus.o_req0_ready;
        r1   = bus.o_req1_ready;
        cred = int'(bus.o_credits);
        err  = bus.o_credit_err;
        ov   = bus.o_valid;
        oop  = '{src0: bus.o_src0_value, src1: bus.o_src1_value, dst_rob: bus.o_dst_rob,
                 fid: bus.o_fid, mul_cmd: bus.o_mul_cmd};
        chk("ready0", 32'(bus.o_req0_ready), 32'(g == 0));
        chk("ready1", 32'(bus.o_req1_ready), 32'(g == 1));
        chk_outputs("model");
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_op    = (g == 0) ? p0 : p1;
            m_ptr   = 1 - g;
        end else begin
            m_valid = 1'b0;
        end
        m_credits = m_credits - ((g >= 0) ? 1 : 0) + (pp ? 1 : 0);
        if (m_credits > CREDITS) begin
            m_credits = CREDITS;
            m_err     = 1'b1;
        end
        #1;
    endtask

    initial begin
        bit      r0, r1, err, ov;
        int      cred;
        mul_op_t oop, p0, p1;

        // Directed sequence from reset (v0 v1 flush pop | ready0 ready1 credits err).
        vecs.push_back(mk(1,0,0,0, 1,0, 4,0)); // single req0 op
        vecs.push_back(mk(0,1,0,0, 0,1, 3,0)); // req0 op visible on o_*
        vecs.push_back(mk(0,0,0,1, 0,0, 2,0));
        vecs.push_back(mk(0,0,0,1, 0,0, 3,0));
        vecs.push_back(mk(1,1,0,0, 1,0, 4,0)); // alternation 0,1,0,1
        vecs.push_back(mk(1,1,0,0, 0,1, 3,0));
        vecs.push_back(mk(1,1,0,0, 1,0, 2,0));
        vecs.push_back(mk(1,1,0,0, 0,1, 1,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0)); // out of credits
        vecs.push_back(mk(1,1,0,1, 0,0, 0,0)); // pop not forwarded
        vecs.push_back(mk(1,1,0,0, 1,0, 1,0)); // grant after pop
        vecs.push_back(mk(0,0,0,1, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,1, 0,0, 1,0));
        vecs.push_back(mk(1,1,0,1, 0,1, 2,0)); // issue + pop same cycle
        vecs.push_back(mk(0,0,0,0, 0,0, 2,0));
        vecs.push_back(mk(1,1,1,0, 0,0, 2,0)); // flush blocks grant
        vecs.push_back(mk(1,1,0,0, 1,0, 2,0)); // pointer untouched by flush
        vecs.push_back(mk(0,0,0,0, 0,0, 1,0));
        vecs.push_back(mk(0,0,0,1, 0,0, 1,0));
        vecs.push_back(mk(0,0,0,1, 0,0, 2,0));
        vecs.push_back(mk(0,0,0,1, 0,0, 3,0));
        vecs.push_back(mk(0,0,0,1, 0,0, 4,0)); // overflow pop
        vecs.push_back(mk(0,0,0,0, 0,0, 4,1));
        vecs.push_back(mk(0,0,0,1, 0,0, 4,1));
        vecs.push_back(mk(0,0,0,0, 0,0, 4,1));

        resetn = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_outputs("reset");
        @(posedge clk);
        #1 resetn = 1'b1;

        foreach (vecs[i]) begin
            p0 = rand_op();
            p1 = rand_op();
            if (i == 0) p0 = '{src0: 32'h3, src1: 32'h5, dst_rob: 4'd2, fid: 8'h11, mul_cmd: 1'b0};
            run_cycle(vecs[i].v0, vecs[i].v1, vecs[i].fl, vecs[i].pp, p0, p1,
                      r0, r1, cred, err, ov, oop);
            chk($sformatf("vec%0d ready0", i),  32'(r0),   32'(vecs[i].er0));
            chk($sformatf("vec%0d ready1", i),  32'(r1),   32'(vecs[i].er1));
            chk($sformatf("vec%0d credits", i), 32'(cred), 32'(vecs[i].ecred));
            chk($sformatf("vec%0d err", i),     32'(err),  32'(vecs[i].eerr));
            if (i == 1) begin
                chk("first op valid", 32'(ov),         32'd1);
                chk("first op src0",  oop.src0,        32'h3);
                chk("first op src1",  oop.src1,        32'h5);
                chk("first op rob",   32'(oop.dst_rob), 32'd2);
                chk("first op fid",   32'(oop.fid),    32'h11);
            end
        end

        // Reset asserted mid-stream while an op is being accepted.
        run_cycle(1, 0, 0, 0, rand_op(), rand_op(), r0, r1, cred, err, ov, oop);
        drive(1, 0, 0, 0, rand_op(), rand_op());
        @(negedge clk);
        chk("pre-reset o_valid", 32'(bus.o_valid), 32'd1);
        resetn = 1'b0;
        #1;
        model_reset();
        chk_outputs("async reset");
        @(posedge clk);
        #1 resetn = 1'b1;
        drive(0, 0, 0, 0, '0, '0);
        run_cycle(0, 0, 0, 0, rand_op(), rand_op(), r0, r1, cred, err, ov, oop);
        chk("no pulse after reset", 32'(ov), 32'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            run_cycle(1'($urandom), 1'($urandom), ($urandom % 8) == 0, ($urandom % 3) == 0,
                      rand_op(), rand_op(), r0, r1, cred, err, ov, oop);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
